// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, ID-side control and IF/ID outputs.
// master = fetch stage, slave = memory/decoder environment.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        sleep_req;
    logic        irq_pending;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;

    modport master (
        output imem_req, imem_addr, if_inst, if_pc, if_valid,
        input  imem_rvalid, imem_rdata, id_stall, redirect_valid, redirect_pc,
               sleep_req, irq_pending
    );

    modport slave (
        input  imem_req, imem_addr, if_inst, if_pc, if_valid,
        output imem_rvalid, imem_rdata, id_stall, redirect_valid, redirect_pc,
               sleep_req, irq_pending
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, single-outstanding imem requests, IF/ID register, redirect and WFI sleep.
// Latency: request-to-IF/ID = memory latency + 1 cycle; one instruction per cycle with 1-cycle memory.
// Backpressure: id_stall holds IF/ID, a 1-entry skid absorbs the in-flight word. Optional: FETCH_PERF_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_bubble_cnt,
    output logic [31:0]   perf_sleep_cnt
`endif
);

    typedef enum logic [1:0] {FETCH, WAIT, DROP, SLEEP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] skid_inst_q, skid_pc_q;
    logic [31:0] if_inst_q, if_pc_q;
    logic        if_valid_q;
    logic        sleep_pend_q, sleep_pend_d;
    logic        resp, issue, load_skid;
    logic [31:0] redir_pc;

    always_comb begin
        redir_pc   = {bus.redirect_pc[31:2], 2'b00};
        resp       = (state_q == WAIT) && bus.imem_rvalid;
        skid_vld_d = skid_vld_q;
        load_skid  = 1'b0;
        if (bus.redirect_valid) begin
            skid_vld_d = 1'b0;
        end else if (resp && (bus.id_stall || skid_vld_q)) begin
            skid_vld_d = 1'b1;
            load_skid  = 1'b1;
        end else if (!bus.id_stall) begin
            skid_vld_d = 1'b0;
        end

        // Issue only if the word it will return has somewhere to land.
        issue = !rst && !bus.redirect_valid && !skid_vld_d &&
                ((state_q == FETCH) || resp);

        pc_d         = pc_q;
        state_d      = state_q;
        sleep_pend_d = sleep_pend_q;
        if (bus.redirect_valid) begin
            pc_d         = redir_pc;
            sleep_pend_d = bus.sleep_req;
            if (((state_q == WAIT) || (state_q == DROP)) && !bus.imem_rvalid)
                state_d = DROP;
            else
                state_d = bus.sleep_req ? SLEEP : FETCH;
        end else begin
            case (state_q)
                FETCH:   if (issue) state_d = WAIT;
                WAIT:    if (resp) state_d = issue ? WAIT : FETCH;
                DROP:    if (bus.imem_rvalid) state_d = sleep_pend_q ? SLEEP : FETCH;
                SLEEP:   if (bus.irq_pending) begin
                             state_d      = FETCH;
                             sleep_pend_d = 1'b0;
                         end
                default: state_d = FETCH;
            endcase
            if (issue) pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            skid_vld_q   <= 1'b0;
            skid_inst_q  <= NOP_INST;
            skid_pc_q    <= 32'd0;
            if_inst_q    <= NOP_INST;
            if_pc_q      <= 32'd0;
            if_valid_q   <= 1'b0;
            sleep_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sleep_pend_q <= sleep_pend_d;
            skid_vld_q   <= skid_vld_d;
            if (issue) req_pc_q <= pc_q;
            if (load_skid) begin
                skid_inst_q <= bus.imem_rdata;
                skid_pc_q   <= req_pc_q;
            end
            if (bus.redirect_valid) begin
                if_inst_q  <= NOP_INST;
                if_valid_q <= 1'b0;
            end else if (!bus.id_stall) begin
                if (skid_vld_q) begin
                    if_inst_q  <= skid_inst_q;
                    if_pc_q    <= skid_pc_q;
                    if_valid_q <= 1'b1;
                end else if (resp) begin
                    if_inst_q  <= bus.imem_rdata;
                    if_pc_q    <= req_pc_q;
                    if_valid_q <= 1'b1;
                end else begin
                    if_inst_q  <= NOP_INST;
                    if_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_valid  = if_valid_q;

`ifdef FETCH_PERF_EN
    logic if_bubble;
    assign if_bubble = !bus.redirect_valid && !bus.id_stall && !skid_vld_q && !resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bubble_cnt <= 32'd0;
            perf_sleep_cnt  <= 32'd0;
        end else begin
            if (if_bubble && (perf_bubble_cnt != 32'hFFFF_FFFF))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if ((state_q == SLEEP) && (perf_sleep_cnt != 32'hFFFF_FFFF))
                perf_sleep_cnt <= perf_sleep_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect/sleep/reset traffic,
// checked against an instruction-stream model (program order, request address stream, sleep quiet).
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    fetch_stage_if bus ();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble_cnt, perf_sleep_cnt;
`endif

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble_cnt(perf_bubble_cnt),
        .perf_sleep_cnt(perf_sleep_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int lat = 1;
    int consumed = 0;
    logic want_rst = 1'b1;

    // memory model: one pending response
    logic        pend = 1'b0;
    logic        pend_stale = 1'b0;
    int          pend_wait = 0;
    logic [31:0] pend_addr = 32'd0;

    // stream model
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] req_exp = RST_PC;
    logic        asleep = 1'b0;
    logic        prev_redir = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_inst, prev_pc;
    logic        prev_vld;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic st, input logic rv, input logic [31:0] rpc,
                        input logic sl, input logic irq);
        @(posedge clk);
        #1;
        rst                = want_rst;
        bus.id_stall       = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.sleep_req      = sl;
        bus.irq_pending    = irq;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = $urandom;
        if (pend) begin
            if (pend_wait == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = pend_stale ? 32'hDEAD_BEEF : mem_word(pend_addr);
                pend = 1'b0;
            end else begin
                pend_wait--;
            end
        end
        #4;
        if (rst) begin
            exp_pc     = RST_PC;
            req_exp    = RST_PC;
            asleep     = 1'b0;
            prev_redir = 1'b0;
            prev_stall = 1'b0;
            if (pend) pend_stale = 1'b1;
        end else begin
            if (prev_redir) begin
                check("flush_vld", 32'(bus.if_valid), 32'd0);
                check("flush_inst", bus.if_inst, NOP);
            end else if (prev_stall) begin
                check("hold_vld", 32'(bus.if_valid), 32'(prev_vld));
                check("hold_pc", bus.if_pc, prev_pc);
                check("hold_inst", bus.if_inst, prev_inst);
            end
            if (rv) check("redir_noreq", 32'(bus.imem_req), 32'd0);
            if (asleep) check("sleep_noreq", 32'(bus.imem_req), 32'd0);
            if (bus.imem_req) begin
                check("req_addr", bus.imem_addr, req_exp);
                req_exp = req_exp + 32'd4;
            end
            if (bus.if_valid && !st && !rv) begin
                check("stream_pc", bus.if_pc, exp_pc);
                check("stream_inst", bus.if_inst, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (rv) begin
                exp_pc  = {rpc[31:2], 2'b00};
                req_exp = {rpc[31:2], 2'b00};
                asleep  = sl;
            end else if (irq) begin
                asleep = 1'b0;
            end
            prev_redir = rv;
            prev_stall = st;
            prev_vld   = bus.if_valid;
            prev_pc    = bus.if_pc;
            prev_inst  = bus.if_inst;
        end
        if (bus.imem_req) begin
            pend       = 1'b1;
            pend_stale = 1'b0;
            pend_addr  = bus.imem_addr;
            pend_wait  = lat - 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outs();
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", bus.imem_addr, RST_PC);
        check("rst_inst", bus.if_inst, NOP);
        check("rst_pc", bus.if_pc, 32'd0);
        check("rst_vld", 32'(bus.if_valid), 32'd0);
    endtask

    task automatic do_reset();
        want_rst = 1'b1;
        idle(2);
        check_reset_outs();
        want_rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic st_r, rv_r, sl_r, irq_r;
        logic [31:0] rpc_r;
        bit   seen;
        rst = 1'b1;
        bus.id_stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0;
        bus.sleep_req = 1'b0; bus.irq_pending = 1'b0;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;

        // back-to-back stream
        do_reset();
        lat = 1;
        idle(1); check("t1_req0", 32'(bus.imem_req), 32'd1); check("t1_addr0", bus.imem_addr, 32'h0);
        idle(1); check("t1_addr1", bus.imem_addr, 32'h4);
        idle(1); check("t1_addr2", bus.imem_addr, 32'h8);
        check("t1_vld", 32'(bus.if_valid), 32'd1); check("t1_pc0", bus.if_pc, 32'h0);
        idle(1); check("t1_pc1", bus.if_pc, 32'h4);
        idle(1); check("t1_pc2", bus.if_pc, 32'h8);

        // stall with skid capture
        do_reset();
        idle(3);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        check("t2_noreq", 32'(bus.imem_req), 32'd0); check("t2_pc", bus.if_pc, 32'h4);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
            check("t2_hold_pc", bus.if_pc, 32'h4); check("t2_skid_noreq", 32'(bus.imem_req), 32'd0);
        end
        idle(1); check("t2_req", 32'(bus.imem_req), 32'd1); check("t2_addr", bus.imem_addr, 32'hC);
        idle(1); check("t2_pc8", bus.if_pc, 32'h8); check("t2_inst8", bus.if_inst, mem_word(32'h8));
        idle(1); check("t2_pcC", bus.if_pc, 32'hC);

        // redirect while a slow response is outstanding
        do_reset();
        lat = 3;
        idle(1);
        lat = 1;
        step(1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b0);
        idle(1); check("t3_vld", 32'(bus.if_valid), 32'd0);
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            idle(1);
            if (bus.imem_req) begin seen = 1; check("t3_addr", bus.imem_addr, 32'h100); end
        end
        check("t3_req_seen", 32'(seen), 32'd1);
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            idle(1);
            if (bus.if_valid) begin seen = 1; check("t3_pc", bus.if_pc, 32'h100); end
        end
        check("t3_vld_seen", 32'(seen), 32'd1);

        // redirect coinciding with a response under stall
        do_reset();
        idle(1);
        step(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        check("t4_vld", 32'(bus.if_valid), 32'd0); check("t4_inst", bus.if_inst, NOP);
        check("t4_req", 32'(bus.imem_req), 32'd1); check("t4_addr", bus.imem_addr, 32'h200);
        idle(3);

        // WFI sleep and interrupt wake
        do_reset();
        idle(1);
        step(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle(1); check("t5_sleep", 32'(bus.imem_req), 32'd0);
        end
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1); check("t5_irqcyc", 32'(bus.imem_req), 32'd0);
        idle(1); check("t5_wake", 32'(bus.imem_req), 32'd1); check("t5_addr", bus.imem_addr, 32'h40);
        idle(3);

        // reset with skid full, then reset with a response in flight
        do_reset();
        idle(3);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        do_reset();
        idle(1); check("t6a_req", 32'(bus.imem_req), 32'd1); check("t6a_addr", bus.imem_addr, RST_PC);
        idle(3);
        do_reset();
        lat = 3;
        idle(1);
        lat = 1;
        do_reset();
        idle(1); check("t6b_req", 32'(bus.imem_req), 32'd1); check("t6b_addr", bus.imem_addr, RST_PC);
        idle(2); check("t6b_vld", 32'(bus.if_valid), 32'd1); check("t6b_inst", bus.if_inst, mem_word(RST_PC));
        idle(2);

        // randomized traffic
        do_reset();
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            lat      = $urandom_range(1, 3);
            want_rst = ($urandom_range(0, 499) == 0);
            st_r     = ($urandom_range(0, 9) < 3);
            rv_r     = ($urandom_range(0, 99) < 4);
            sl_r     = ($urandom_range(0, 9) < 3);
            irq_r    = ($urandom_range(0, 99) < 8);
            rpc_r    = $urandom & 32'h0000_FFFF;
            step(st_r, rv_r, rpc_r, sl_r, irq_r);
        end
        want_rst = 1'b0;
        check("rand_progress", 32'(consumed > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
